// File: rtl/rtfifo_sched_pkg.sv
// Shared definitions for the Tx/Rx FIFO scheduler: FSM encoding, queue
// select values and the fixed request priority.
package rtfifo_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b1000,
        ST_WR    = 4'b0100,
        ST_RD    = 4'b0010,
        ST_FETCH = 4'b0001
    } state_e;

    localparam logic Q_TX = 1'b0;
    localparam logic Q_RX = 1'b1;

    // Request slots, lowest index wins the grant
    localparam int unsigned NREQ      = 4;
    localparam int unsigned REQ_RF_RD = 0;
    localparam int unsigned REQ_TF_WR = 1;
    localparam int unsigned REQ_RF_WR = 2;
    localparam int unsigned REQ_TF_RD = 3;

    function automatic logic [NREQ-1:0] prio_pick(input logic [NREQ-1:0] req);
        return req & NREQ'(~req + NREQ'(1));
    endfunction

endpackage

// File: rtl/rtfifo_qctl.sv
// Per-queue bookkeeping: pointers, occupancy count, EF/FF flags and the
// pending write/read request bits fed to the shared scheduler.
module rtfifo_qctl
    import rtfifo_sched_pkg::*;
#(
    parameter int unsigned pRTFIFO_Bits = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    flush,
    input  logic                    wr_stb,
    input  logic                    rd_stb,
    input  logic                    wr_gnt,
    input  logic                    rd_gnt,
    input  logic                    do_wr,
    input  logic                    do_rd,
    output logic                    wr_req_c,
    output logic                    rd_req_c,
    output logic                    ef,
    output logic                    ff,
    output logic [pRTFIFO_Bits-1:0] wptr,
    output logic [pRTFIFO_Bits-1:0] rptr,
    output logic [pRTFIFO_Bits:0]   count
);

    localparam int unsigned PW    = pRTFIFO_Bits;
    localparam int unsigned CW    = pRTFIFO_Bits + 1;
    localparam int unsigned DEPTH = 2 ** pRTFIFO_Bits;

    logic          pend_wr;
    logic          pend_rd;
    logic          full_c;
    logic          empty_c;
    logic [CW-1:0] count_nxt_c;

    // A pending request is only offered while it can still legally complete
    always_comb begin
        full_c      = (count == CW'(DEPTH));
        empty_c     = (count == '0);
        count_nxt_c = count;
        if (do_wr && !do_rd) begin
            count_nxt_c = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt_c = count - CW'(1);
        end
        wr_req_c = pend_wr && !full_c && !flush;
        rd_req_c = pend_rd && !empty_c && !flush;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            pend_wr <= 1'b0;
            pend_rd <= 1'b0;
            ef      <= 1'b1;
            ff      <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            pend_wr <= 1'b0;
            pend_rd <= 1'b0;
            ef      <= 1'b1;
            ff      <= 1'b0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + PW'(1);
            end
            count <= count_nxt_c;
            ef    <= (count_nxt_c == '0);
            ff    <= (count_nxt_c == CW'(DEPTH));

            // Strobes hitting an already-pending bit are dropped; stale bits are retired
            if (pend_wr) begin
                if (wr_gnt || full_c) begin
                    pend_wr <= 1'b0;
                end
            end else if (wr_stb && !full_c) begin
                pend_wr <= 1'b1;
            end

            if (pend_rd) begin
                if (rd_gnt || empty_c) begin
                    pend_rd <= 1'b0;
                end
            end else if (rd_stb && !empty_c) begin
                pend_rd <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtfifo_sched.sv
// Scheduler sharing one single-port RAM between a Tx and an Rx FIFO:
// arbitrates pending requests and sequences WR, RD and head-refetch cycles.
module rtfifo_sched
    import rtfifo_sched_pkg::*;
#(
    parameter int unsigned pRTFIFO_Bits = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  TF_Rst,
    input  logic                  RF_Rst,
    input  logic                  TF_Wr,
    input  logic                  TF_Rd,
    input  logic                  RF_Wr,
    input  logic                  RF_Rd,
    output logic                  TF_EF,
    output logic                  TF_FF,
    output logic                  RF_EF,
    output logic                  RF_FF,
    output logic [pRTFIFO_Bits:0] RAM_Addr,
    output logic                  RAM_WE,
    output logic                  RAM_Sel,
    output logic                  WE_TDO,
    output logic                  WE_RDO,
    output logic                  Busy
);

    localparam int unsigned PW = pRTFIFO_Bits;
    localparam int unsigned CW = pRTFIFO_Bits + 1;

    state_e        state;
    logic          q;
    logic [CW-1:0] ram_addr_r;
    logic          ram_we_r;
    logic          ram_sel_r;
    logic          we_tdo_r;
    logic          we_rdo_r;
    logic          busy_r;

    logic          tx_wr_req_c, tx_rd_req_c, rx_wr_req_c, rx_rd_req_c;
    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_do_wr, tx_do_rd, rx_do_wr, rx_do_rd;

    logic [NREQ-1:0] req_c;
    logic [NREQ-1:0] gnt_c;
    logic            gnt_q_c;
    logic            gnt_wr_c;
    logic            gnt_empty_c;
    logic [PW-1:0]   gnt_wptr_c;
    logic [PW-1:0]   gnt_rptr_c;
    logic [PW-1:0]   cur_rptr_c;
    logic [CW-1:0]   cur_count_c;
    logic            flush_cur_c;

    rtfifo_qctl #(.pRTFIFO_Bits(pRTFIFO_Bits)) u_tx (
        .Clk      (Clk),
        .Rst      (Rst),
        .flush    (TF_Rst),
        .wr_stb   (TF_Wr),
        .rd_stb   (TF_Rd),
        .wr_gnt   (gnt_c[REQ_TF_WR]),
        .rd_gnt   (gnt_c[REQ_TF_RD]),
        .do_wr    (tx_do_wr),
        .do_rd    (tx_do_rd),
        .wr_req_c (tx_wr_req_c),
        .rd_req_c (tx_rd_req_c),
        .ef       (TF_EF),
        .ff       (TF_FF),
        .wptr     (tx_wptr),
        .rptr     (tx_rptr),
        .count    (tx_count)
    );

    rtfifo_qctl #(.pRTFIFO_Bits(pRTFIFO_Bits)) u_rx (
        .Clk      (Clk),
        .Rst      (Rst),
        .flush    (RF_Rst),
        .wr_stb   (RF_Wr),
        .rd_stb   (RF_Rd),
        .wr_gnt   (gnt_c[REQ_RF_WR]),
        .rd_gnt   (gnt_c[REQ_RF_RD]),
        .do_wr    (rx_do_wr),
        .do_rd    (rx_do_rd),
        .wr_req_c (rx_wr_req_c),
        .rd_req_c (rx_rd_req_c),
        .ef       (RF_EF),
        .ff       (RF_FF),
        .wptr     (rx_wptr),
        .rptr     (rx_rptr),
        .count    (rx_count)
    );

    assign tx_do_wr = (state == ST_WR) && (q == Q_TX);
    assign rx_do_wr = (state == ST_WR) && (q == Q_RX);
    assign tx_do_rd = (state == ST_RD) && (q == Q_TX);
    assign rx_do_rd = (state == ST_RD) && (q == Q_RX);

    // Arbitration and per-queue muxing
    always_comb begin
        req_c            = '0;
        req_c[REQ_RF_RD] = rx_rd_req_c;
        req_c[REQ_TF_WR] = tx_wr_req_c;
        req_c[REQ_RF_WR] = rx_wr_req_c;
        req_c[REQ_TF_RD] = tx_rd_req_c;
        gnt_c            = (state == ST_IDLE) ? prio_pick(req_c) : '0;
        gnt_q_c          = gnt_c[REQ_RF_RD] | gnt_c[REQ_RF_WR];
        gnt_wr_c         = gnt_c[REQ_TF_WR] | gnt_c[REQ_RF_WR];
        gnt_wptr_c       = gnt_q_c ? rx_wptr : tx_wptr;
        gnt_rptr_c       = gnt_q_c ? rx_rptr : tx_rptr;
        gnt_empty_c      = gnt_q_c ? RF_EF : TF_EF;
        cur_rptr_c       = q ? rx_rptr : tx_rptr;
        cur_count_c      = q ? rx_count : tx_count;
        flush_cur_c      = q ? RF_Rst : TF_Rst;
    end

    // A flush of the active queue kills its strobes in the same cycle
    assign RAM_WE   = ram_we_r & ~flush_cur_c;
    assign WE_TDO   = we_tdo_r & ~flush_cur_c;
    assign WE_RDO   = we_rdo_r & ~flush_cur_c;
    assign RAM_Addr = ram_addr_r;
    assign RAM_Sel  = ram_sel_r;
    assign Busy     = busy_r;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_IDLE;
            q          <= Q_TX;
            ram_addr_r <= '0;
            ram_we_r   <= 1'b0;
            ram_sel_r  <= 1'b0;
            we_tdo_r   <= 1'b0;
            we_rdo_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ram_addr_r <= '0;
            ram_we_r   <= 1'b0;
            ram_sel_r  <= 1'b0;
            we_tdo_r   <= 1'b0;
            we_rdo_r   <= 1'b0;
            busy_r     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt_c) begin
                        q         <= gnt_q_c;
                        busy_r    <= 1'b1;
                        ram_sel_r <= gnt_q_c;
                        if (gnt_wr_c) begin
                            state      <= ST_WR;
                            ram_we_r   <= 1'b1;
                            ram_addr_r <= {gnt_q_c, gnt_wptr_c};
                            we_tdo_r   <= gnt_empty_c && (gnt_q_c == Q_TX);
                            we_rdo_r   <= gnt_empty_c && (gnt_q_c == Q_RX);
                        end else begin
                            state      <= ST_RD;
                            ram_addr_r <= {gnt_q_c, gnt_rptr_c};
                        end
                    end
                end
                // Refetch the new head only if the read leaves data behind
                ST_RD: begin
                    if (!flush_cur_c && (cur_count_c != CW'(1))) begin
                        state      <= ST_FETCH;
                        busy_r     <= 1'b1;
                        ram_sel_r  <= q;
                        ram_addr_r <= {q, PW'(cur_rptr_c + PW'(1))};
                        we_tdo_r   <= (q == Q_TX);
                        we_rdo_r   <= (q == Q_RX);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rtfifo_sched.md
RTFIFO_SCHED -- requirements
Module: rtfifo_sched

Interface
REQ-001 SHALL have parameter pRTFIFO_Bits, default 2, meaning log2 of the per-FIFO depth (depth D = 2**pRTFIFO_Bits).
REQ-002 SHALL have the port Clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have the port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have TF_Rst and RF_Rst, input, 1 bit each: synchronous flush of the Tx/Rx queue.
REQ-005 SHALL have TF_Wr, TF_Rd, RF_Wr and RF_Rd, input, 1 bit each: single-cycle request strobes.
REQ-006 SHALL have TF_EF, TF_FF, RF_EF and RF_FF, output, 1 bit each: empty/full flags per queue.
REQ-007 SHALL have RAM_Addr, output, pRTFIFO_Bits+1 bits: shared single-port RAM address; MSB 0 = Tx half, 1 = Rx half.
REQ-008 SHALL have RAM_WE, output, 1 bit: RAM write enable.
REQ-009 SHALL have RAM_Sel, output, 1 bit: write-data mux select; 0 = TDI, 1 = RDI.
REQ-010 SHALL have WE_TDO and WE_RDO, output, 1 bit each: load strobes for the external TDO/RDO head registers, which load the RAM read data (zero-latency read).
REQ-011 SHALL have Busy, output, 1 bit: state is not IDLE.

Function
REQ-012 Each queue SHALL keep a write pointer and a read pointer (pRTFIFO_Bits bits each, wrapping modulo D) and a count (pRTFIFO_Bits+1 bits).
REQ-013 EF SHALL be count==0 and FF SHALL be count==D, both registered from count.
REQ-014 A strobe SHALL set that request's pending bit only when the target queue is not full (write) or not empty (read) in the strobe cycle; otherwise the strobe is dropped with no side effect.
REQ-015 A strobe arriving while the same pending bit is already set SHALL be dropped.
REQ-016 The FSM states SHALL be IDLE, WR, RD and FETCH, each with a registered queue-select bit Q (0 = Tx, 1 = Rx).
REQ-017 In IDLE with any pending bit set, the FSM SHALL grant one request, clear its pending bit and move next cycle to WR or RD.
REQ-018 Grant priority SHALL be RF_Rd > TF_Wr > RF_Wr > TF_Rd.
REQ-019 WR SHALL last one cycle: RAM_Addr={Q,wptr}, RAM_WE=1, RAM_Sel=Q, wptr+1, count+1; if count was 0, WE_xDO=1 in the same cycle (head load); then IDLE.
REQ-020 RD SHALL last one cycle: rptr+1, count-1; go to FETCH if the new count is nonzero, else to IDLE with the head register left unchanged.
REQ-021 FETCH SHALL last one cycle: RAM_Addr={Q,rptr}, WE_xDO=1; then IDLE.
REQ-022 Outside WR, RAM_WE SHALL be 0; in IDLE, RAM_Addr SHALL be 0 and RAM_Sel 0.
REQ-023 Per-request latency from strobe to completion: write 3 cycles (strobe, grant, WR); read 3 or 4 cycles, plus queueing behind higher-priority requests.
REQ-024 Simultaneous strobes on all four inputs SHALL all latch and complete in priority order without loss.
REQ-025 A flush SHALL zero that queue's pointers, count and both pending bits; if the FSM is in WR, RD or FETCH for that queue, it SHALL return to IDLE with no RAM_WE or WE_xDO in that cycle.
REQ-026 A flush SHALL override a same-cycle strobe to the same queue and SHALL NOT affect the other queue.

Reset
REQ-027 Rst SHALL asynchronously force IDLE, Q=0, all pointers/counts/pending bits 0, TF_EF=RF_EF=1, TF_FF=RF_FF=0, and RAM_WE, WE_TDO, WE_RDO, Busy, RAM_Addr and RAM_Sel to 0.

Structure
REQ-028 A shared package SHALL hold the state encoding (one-hot, IDLE=4'b1000), the priority order and the Q select constants.
REQ-029 One sub-module, rtfifo_qctl (pointer/count/flag/pending logic), SHALL be instantiated twice, once per queue; the FSM and arbiter SHALL stay in rtfifo_sched.

Verification (pRTFIFO_Bits=2, D=4)
REQ-030 After reset, TF_Wr and RF_Wr pulsed together -> WR(Q=0) with RAM_Addr=3'b000 and WE_TDO=1, then WR(Q=1) with RAM_Addr=3'b100 and WE_RDO=1; RF_EF stays 1 until the second WR.
REQ-031 Four writes per queue -> TF_FF=RF_FF=1; a fifth TF_Wr is dropped: Busy stays 0 and no RAM_WE occurs for 4 cycles.
REQ-032 With both queues full, TF_Rd and RF_Rd pulsed together -> RD/FETCH(Q=1) with RAM_Addr=3'b101 completes before RD(Q=0); both FF flags end at 0.
REQ-033 Drain to empty -> the final RD goes straight to IDLE with no WE_xDO and EF=1; a further read strobe yields no Busy.
REQ-034 TF_Rst asserted during WR(Q=0) -> RAM_WE=0 in that cycle, TF count 0, TF_EF=1, and RF pointers/count unchanged.
REQ-035 Rst asserted mid-FETCH -> all outputs reach their reset values immediately, without waiting for a clock edge.
